// File: rtl/alu_pkg.sv
// Shared ALU op encodings and flag bundle for the N-bit ALU and its core.
// Latency: n/a (types only). Backpressure: n/a. SLL/SRL codes are only legal with ALU_SHIFT_EN.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: result and flags from a, b and op.
// Latency: 0 cycles. Backpressure: none. ALU_SHIFT_EN enables SLL/SRL, otherwise they are illegal.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags
);

`ifdef ALU_SHIFT_EN
   localparam int SHW = $clog2(WIDTH);
`endif

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             ovf;

   // One shared adder: ADD uses b, SUB and SLT use ~b + 1.
   always_comb begin
      cin   = (op != ALU_ADD);
      b_eff = cin ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

   always_comb begin
      result = '0;
      flags  = '0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_ADD, ALU_SUB: begin
            result         = sum[WIDTH-1:0];
            flags.carry    = sum[WIDTH];
            flags.overflow = ovf;
         end
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
`ifdef ALU_SHIFT_EN
         ALU_SLL: result = a << b[SHW-1:0];
         ALU_SRL: result = a >> b[SHW-1:0];
`endif
         default: flags.illegal = 1'b1;
      endcase
      flags.zero = (result == '0);
   end

endmodule

// File: rtl/alu_nbit_pipe.sv
// Two-stage pipelined N-bit ALU with valid/ready on both sides (ALU_SHIFT_EN adds SLL/SRL).
// Latency: 2 cycles from input transfer to out_valid; 1 op/cycle. Backpressure: in_ready falls
// combinationally from out_ready when both stages are full; no skid buffer, stalled output held.
module alu_nbit_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal_op
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   alu_flags_t       flags_q, flags_d;

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] core_result;
   alu_flags_t       core_flags;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (core_result),
      .flags  (core_flags)
   );

   always_comb begin
      s2_adv = !s2_valid_q || out_ready;
      s1_adv = !s1_valid_q || s2_adv;

      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d  = a;
            b_d  = b;
            op_d = alu_op;
         end
      end

      // Bubbles advance the valid bit only, so the last result stays visible but unflagged.
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = core_result;
            flags_d  = core_flags;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign in_ready   = s1_adv;
   assign out_valid  = s2_valid_q;
   assign result     = result_q;
   assign carry_out  = flags_q.carry;
   assign overflow   = flags_q.overflow;
   assign zero       = flags_q.zero;
   assign illegal_op = flags_q.illegal;

endmodule

// File: tb/tb_alu_nbit_pipe.sv
// Bench for alu_nbit_pipe at WIDTH=8: directed vectors, backpressure, random streaming, reset.
module tb_alu_nbit_pipe;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         illegal_op;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] r;
      logic       c;
      logic       v;
      logic       il;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] r;
      logic       c;
      logic       v;
      logic       z;
   } vec_t;

   logic [3:0] op_pool [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'hF};

   alu_nbit_pipe #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .alu_op     (alu_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .carry_out  (carry_out),
      .overflow   (overflow),
      .zero       (zero),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference semantics in plain integer arithmetic.
   function automatic exp_t ref_alu(input logic [7:0] x, input logic [7:0] y, input logic [3:0] op);
      exp_t e;
      int   ux, uy, sx, sy, sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      e  = '{r: 8'h00, c: 1'b0, v: 1'b0, il: 1'b0};
      case (op)
         4'h0: e.r = x & y;
         4'h1: e.r = x | y;
         4'hC: e.r = ~(x | y);
         4'h2: begin
            e.r = 8'(ux + uy);
            e.c = (ux + uy) > 255;
            sr  = sx + sy;
            e.v = (sr > 127) || (sr < -128);
         end
         4'h6: begin
            e.r = 8'(ux - uy);
            e.c = (ux >= uy);
            sr  = sx - sy;
            e.v = (sr > 127) || (sr < -128);
         end
         4'h7: e.r = (sx < sy) ? 8'h01 : 8'h00;
`ifdef ALU_SHIFT_EN
         4'h3: e.r = 8'(ux << (uy % 8));
         4'h4: e.r = 8'(ux >> (uy % 8));
`endif
         default: e.il = 1'b1;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      alu_op    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      tests++;
      if (out_valid !== 1'b0 || result !== 8'h00) begin
         fails++;
         $display("FAIL reset_out: out_valid=%b result=%h, want 0/00", out_valid, result);
      end
      tests++;
      if ({carry_out, overflow, zero, illegal_op} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: c/v/z/il=%b, want 0000", {carry_out, overflow, zero, illegal_op});
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      vec_t v [8];
      v[0] = '{8'h7F, 8'h01, 4'h2, 8'h80, 1'b0, 1'b1, 1'b0};
      v[1] = '{8'h05, 8'h05, 4'h6, 8'h00, 1'b1, 1'b0, 1'b1};
      v[2] = '{8'hFF, 8'h01, 4'h7, 8'h01, 1'b0, 1'b0, 1'b0};
      v[3] = '{8'h80, 8'h7F, 4'h7, 8'h01, 1'b0, 1'b0, 1'b0};
      v[4] = '{8'hF0, 8'h3C, 4'h0, 8'h30, 1'b0, 1'b0, 1'b0};
      v[5] = '{8'h00, 8'h00, 4'hC, 8'hFF, 1'b0, 1'b0, 1'b0};
      v[6] = '{8'hFF, 8'h01, 4'h2, 8'h00, 1'b1, 1'b0, 1'b1};
      v[7] = '{8'h80, 8'h01, 4'h6, 8'h7F, 1'b1, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a        = v[i].a;
         b        = v[i].b;
         alu_op   = v[i].op;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL dir%0d_early: out_valid=%b one cycle after accept, want 0", i, out_valid);
         end
         tick();
         tests++;
         if (out_valid !== 1'b1 || result !== v[i].r || carry_out !== v[i].c ||
             overflow !== v[i].v || zero !== v[i].z || illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL dir%0d: vld=%b r=%h c=%b v=%b z=%b il=%b, want 1 r=%h c=%b v=%b z=%b il=0",
                     i, out_valid, result, carry_out, overflow, zero, illegal_op,
                     v[i].r, v[i].c, v[i].v, v[i].z);
         end
      end
      tick();
   endtask

   task automatic test_illegal();
      logic [3:0] ops [2] = '{4'hF, 4'h3};
      exp_t       e;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a        = 8'hA5;
         b        = 8'h02;
         alu_op   = ops[i];
         in_valid = 1'b1;
         e        = ref_alu(a, b, alu_op);
         tick();
         in_valid = 1'b0;
         tick();
         tests++;
         if (out_valid !== 1'b1 || illegal_op !== e.il || result !== e.r ||
             zero !== (e.r == 8'h00) || carry_out !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL illegal_op%h: vld=%b il=%b r=%h z=%b c=%b v=%b, want 1 il=%b r=%h z=%b c=0 v=0",
                     ops[i], out_valid, illegal_op, result, zero, carry_out, overflow,
                     e.il, e.r, (e.r == 8'h00));
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      exp_t q[$];
      exp_t e;
      int   accepted = 0;
      int   got = 0;
      int   first_out = -1;
      int   last_out = -1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a        = 8'($urandom);
         b        = 8'($urandom);
         alu_op   = 4'h2;
         in_valid = 1'b1;
         #1;
         if (in_ready) begin
            q.push_back(ref_alu(a, b, alu_op));
            accepted++;
         end
         if (i < 2) tick();
      end
      tests++;
      if (accepted != 2 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_fill: accepted=%0d in_ready=%b, want 2/0", accepted, in_ready);
      end
      for (int s = 0; s < 3; s++) begin
         tick();
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== q[0].r || carry_out !== q[0].c) begin
            fails++;
            $display("FAIL bp_hold%0d: vld=%b rdy=%b r=%h c=%b, want 1 0 r=%h c=%b",
                     s, out_valid, in_ready, result, carry_out, q[0].r, q[0].c);
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10 && got < 3; c++) begin
         #1;
         if (in_valid && in_ready) begin
            q.push_back(ref_alu(a, b, alu_op));
         end
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL bp_drain: unexpected output r=%h, want none", result);
            end else begin
               e = q.pop_front();
               if (result !== e.r || carry_out !== e.c || overflow !== e.v) begin
                  fails++;
                  $display("FAIL bp_drain%0d: r=%h c=%b v=%b, want r=%h c=%b v=%b",
                           got, result, carry_out, overflow, e.r, e.c, e.v);
               end
            end
            if (first_out < 0) first_out = c;
            last_out = c;
            got++;
         end
         tick();
         in_valid = 1'b0;
      end
      tests++;
      if (got != 3 || (last_out - first_out) != 2) begin
         fails++;
         $display("FAIL bp_order: outputs=%0d span=%0d, want 3 outputs over 3 consecutive cycles",
                  got, last_out - first_out);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_streaming();
      exp_t q[$];
      exp_t e;
      int   sent = 0;
      int   got = 0;
      bit   need_new = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 20; c++) begin
         if (sent < 20 && need_new) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            alu_op   = op_pool[$urandom_range(0, 7)];
            in_valid = 1'b1;
            need_new = 1'b0;
         end else if (sent >= 20) begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            q.push_back(ref_alu(a, b, alu_op));
            sent++;
            need_new = 1'b1;
         end
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL stream_extra: output r=%h with nothing in flight", result);
            end else begin
               e = q.pop_front();
               if (result !== e.r || carry_out !== e.c || overflow !== e.v ||
                   zero !== (e.r == 8'h00) || illegal_op !== e.il || c != got + 2) begin
                  fails++;
                  $display("FAIL stream%0d: cyc=%0d r=%h c=%b v=%b z=%b il=%b, want cyc=%0d r=%h c=%b v=%b z=%b il=%b",
                           got, c, result, carry_out, overflow, zero, illegal_op,
                           got + 2, e.r, e.c, e.v, (e.r == 8'h00), e.il);
               end
            end
            got++;
         end
         tick();
      end
      in_valid = 1'b0;
      tests++;
      if (got != 20) begin
         fails++;
         $display("FAIL stream_count: got %0d results, want 20", got);
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a        = 8'($urandom);
         b        = 8'($urandom);
         alu_op   = 4'h2;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre: out_valid=%b before reset, want 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_async: vld=%b r=%h z=%b rdy=%b, want 0 00 0 1", out_valid, result, zero, in_ready);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_stale%0d: out_valid=%b after release, want 0", s, out_valid);
         end
      end
      a        = 8'h12;
      b        = 8'h34;
      alu_op   = 4'h6;
      in_valid = 1'b1;
      e        = ref_alu(a, b, alu_op);
      tick();
      in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b1 || result !== e.r || carry_out !== e.c) begin
         fails++;
         $display("FAIL rst_first: vld=%b r=%h c=%b, want 1 r=%h c=%b", out_valid, result, carry_out, e.r, e.c);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_backpressure();
      test_streaming();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
